// File: rtl/instr_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream, packs big-endian
// words and writes them to instruction memory from BASE, holding the core in reset until done.
module instr_loader #(
   parameter int                 A_WIDTH   = 32,
   parameter logic [A_WIDTH-1:0] BASE      = 32'hBFC00000,
   parameter int                 MAX_WORDS = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic               byte_ready,
   output logic               mem_we,
   output logic [A_WIDTH-1:0] mem_addr,
   output logic [31:0]        mem_wdata,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               cpu_rst_n
);

   localparam int WW = $clog2(MAX_WORDS + 1);

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

   state_t             r_state;
   logic [23:0]        r_shift;
   logic [1:0]         r_cnt;
   logic [WW-1:0]      r_len;
   logic [WW-1:0]      r_widx;
   logic [A_WIDTH-1:0] r_addr;
   logic [31:0]        r_wdata;
   logic               r_we, r_ready, r_busy, r_done, r_err, r_cpu_rst_n;

   logic               w_xfer;
   logic [31:0]        w_shift;
   logic [WW-1:0]      w_widx_nx;

   assign w_xfer    = byte_valid & r_ready;
   assign w_shift   = {r_shift, byte_data};
   assign w_widx_nx = r_widx + WW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_len       <= '0;
         r_widx      <= '0;
         r_addr      <= BASE;
         r_wdata     <= '0;
         r_we        <= 1'b0;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_cpu_rst_n <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state     <= S_LEN;
                  r_ready     <= 1'b1;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_err       <= 1'b0;
                  r_cpu_rst_n <= 1'b0;
                  r_cnt       <= '0;
                  r_widx      <= '0;
                  r_addr      <= BASE;
               end
            end
            S_LEN: begin
               if (w_xfer) begin
                  r_shift <= w_shift[23:0];
                  r_cnt   <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     if (w_shift == 32'd0) begin
                        r_state     <= S_DONE;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_cpu_rst_n <= 1'b1;
                     end else if (w_shift > 32'(MAX_WORDS)) begin
                        r_state <= S_ERR;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                     end else begin
                        r_state <= S_DATA;
                        r_len   <= w_shift[WW-1:0];
                     end
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_shift <= w_shift[23:0];
                  r_cnt   <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     r_wdata <= w_shift;
                     r_we    <= 1'b1;
                     r_ready <= 1'b0;
                     r_state <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               // address/data were presented this cycle; step to the next word slot
               r_widx <= w_widx_nx;
               r_addr <= r_addr + A_WIDTH'(4);
               if (w_widx_nx == r_len) begin
                  r_state     <= S_DONE;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_cpu_rst_n <= 1'b1;
               end else begin
                  r_state <= S_DATA;
                  r_ready <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign byte_ready = r_ready;
   assign mem_we     = r_we;
   assign mem_addr   = r_addr;
   assign mem_wdata  = r_wdata;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign cpu_rst_n  = r_cpu_rst_n;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: directed byte streams push expected writes,
// a negedge monitor pops and compares every mem_we cycle.
module tb_instr_loader;

   localparam logic [31:0] BASE = 32'hBFC00000;

   logic        clk, rst_n, start, byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready, mem_we, busy, done, err, cpu_rst_n;
   logic [31:0] mem_addr, mem_wdata;

   instr_loader #(.A_WIDTH(32), .BASE(32'hBFC00000), .MAX_WORDS(1024)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
      .err(err), .cpu_rst_n(cpu_rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int wc_prev = 0, wc_last = 0;
   logic [63:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // monitor: every write cycle must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         logic [63:0] e;
         wc_prev = wc_last;
         wc_last = cyc;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               bad++;
               $display("FAIL write: got addr %h data %h expected addr %h data %h",
                        mem_addr, mem_wdata, e[63:32], e[31:0]);
            end
         end
         total++;
         if (byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_write: got %b expected 0", byte_ready);
         end
      end
   end

   // transfers one byte; returns on the negedge after the accepting edge
   task automatic send(input logic [7:0] b, input int gap);
      int n = 0;
      while (!byte_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         check("ready_timeout", 32'(byte_ready), 32'd1);
         byte_valid = 1'b0;
         return;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      if (gap > 0) begin
         byte_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      logic [31:0] t;
      t = w;
      for (int i = 3; i >= 0; i--) send(t[i*8 +: 8], gap);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, 32'(byte_ready), 32'd0);
      check({tag, "_we"},    32'(mem_we),     32'd0);
      check({tag, "_addr"},  mem_addr,        BASE);
      check({tag, "_wdata"}, mem_wdata,       32'd0);
      check({tag, "_busy"},  32'(busy),       32'd0);
      check({tag, "_done"},  32'(done),       32'd0);
      check({tag, "_err"},   32'(err),        32'd0);
      check({tag, "_cpurst"},32'(cpu_rst_n),  32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;

      // 1: two-word load, valid held high
      do_start();
      check("start_ready", 32'(byte_ready), 32'd1);
      check("start_busy",  32'(busy),       32'd1);
      push(BASE, 32'hDEADBEEF);
      push(BASE + 32'd4, 32'h12345678);
      send_word(32'd2, 0);
      send_word(32'hDEADBEEF, 0);
      send_word(32'h12345678, 0);
      byte_valid = 1'b0;
      check("t1_we_after_last", 32'(mem_we), 32'd1);
      @(negedge clk);
      check("t1_spacing", 32'(wc_last - wc_prev), 32'd5);
      check("t1_done",  32'(done),      32'd1);
      check("t1_cpurst",32'(cpu_rst_n), 32'd1);
      check("t1_busy",  32'(busy),      32'd0);

      // 2: same stream, valid toggled
      do_start();
      check("t2_cpurst_low", 32'(cpu_rst_n), 32'd0);
      push(BASE, 32'hDEADBEEF);
      push(BASE + 32'd4, 32'h12345678);
      send_word(32'd2, 1);
      send_word(32'hDEADBEEF, 1);
      check("t2_ready_data", 32'(byte_ready), 32'd1);
      send_word(32'h12345678, 1);
      repeat (2) @(negedge clk);
      check("t2_done", 32'(done), 32'd1);

      // 3: zero-length image
      do_start();
      check("t3_done_clr", 32'(done), 32'd0);
      send_word(32'd0, 0);
      byte_valid = 1'b0;
      check("t3_done",   32'(done),      32'd1);
      check("t3_cpurst", 32'(cpu_rst_n), 32'd1);

      // 4: oversize header
      do_start();
      send_word(32'h00000401, 0);
      byte_valid = 1'b0;
      check("t4_err",    32'(err),        32'd1);
      check("t4_ready",  32'(byte_ready), 32'd0);
      check("t4_cpurst", 32'(cpu_rst_n),  32'd0);
      repeat (4) @(negedge clk);
      check("t4_cpurst_hold", 32'(cpu_rst_n), 32'd0);
      do_start();
      check("t4_err_clr",  32'(err),        32'd0);
      check("t4_relen",    32'(byte_ready), 32'd1);
      send_word(32'd0, 0);
      byte_valid = 1'b0;
      check("t4_done", 32'(done), 32'd1);

      // 5: reset mid-load
      do_start();
      push(BASE, 32'hA1A2A3A4);
      send_word(32'd2, 0);
      send_word(32'hA1A2A3A4, 0);
      send(8'hB1, 0);
      send(8'hB2, 0);
      byte_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      do_start();
      push(BASE, 32'hCAFEF00D);
      send_word(32'd1, 0);
      send_word(32'hCAFEF00D, 0);
      byte_valid = 1'b0;
      @(negedge clk);
      check("t5_done", 32'(done), 32'd1);

      // 6: start during DATA ignored, then restart after DONE
      do_start();
      push(BASE, 32'h01020304);
      push(BASE + 32'd4, 32'h05060708);
      send_word(32'd2, 0);
      send(8'h01, 0);
      send(8'h02, 0);
      byte_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t6_busy", 32'(busy), 32'd1);
      send(8'h03, 0);
      send(8'h04, 0);
      send_word(32'h05060708, 0);
      byte_valid = 1'b0;
      @(negedge clk);
      check("t6_done", 32'(done), 32'd1);
      do_start();
      check("t6_cpurst_low", 32'(cpu_rst_n), 32'd0);
      check("t6_addr_base",  mem_addr,       BASE);
      push(BASE, 32'h00000013);
      send_word(32'd1, 0);
      send_word(32'h00000013, 0);
      byte_valid = 1'b0;
      @(negedge clk);
      check("t6_done2", 32'(done), 32'd1);

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader that writes instruction memory, which the core only reads. It accepts a byte stream over a valid/ready handshake: a 4-byte big-endian length header, then the program bytes. It packs each group of 4 bytes into a 32-bit word and issues one word write per group, starting at the reset vector. It holds the core in reset until the image is complete.

## Interface
- A_WIDTH, 32, address width of the instruction memory write port.
- BASE, 32'hBFC00000, byte address of the first program word (reset vector).
- MAX_WORDS, 1024, capacity in 32-bit words (covers 0xBFC00000–0xBFC00FFF).
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- byte_valid  input  1  a source byte is present on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts byte_data this cycle.
- mem_we  output  1  one-cycle word-write strobe.
- mem_addr  output  A_WIDTH  byte address of the word being written; always 4-aligned.
- mem_wdata  output  32  word data; [31:24]→mem_addr, [23:16]→+1, [15:8]→+2, [7:0]→+3.
- busy  output  1  a load is in progress (LEN, DATA or WRITE state).
- done  output  1  the image loaded successfully.
- err  output  1  the header length exceeded MAX_WORDS.
- cpu_rst_n  output  1  active-low reset to the core; low until DONE.

## Operation
- A byte transfers on a rising edge where byte_valid and byte_ready are both high. Nothing else transfers a byte.
- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE: byte_ready=0. On start, go to LEN; clear the byte counter, word counter and done/err; set the address to BASE; drive cpu_rst_n low.
- LEN: byte_ready=1. Shift in 4 bytes, MSB first, to form a 32-bit word count N.
  - After the 4th byte: if N==0, go to DONE.
  - If N>MAX_WORDS, go to ERR.
  - Otherwise go to DATA.
- DATA: byte_ready=1. Shift bytes into the word register MSB first. On the 4th byte, latch the word and go to WRITE.
- WRITE: byte_ready=0, mem_we=1 for exactly one cycle. mem_addr = BASE + 4*word_index, and mem_wdata holds the packed word.
  - Next cycle: increment word_index and advance the address by 4.
  - If word_index+1==N, go to DONE; otherwise go to DATA.
- DONE: done=1 and cpu_rst_n=1, held until the next start. start here re-enters LEN and drops cpu_rst_n low the next cycle.
- ERR: err=1, byte_ready=0, cpu_rst_n=0, no writes. start re-enters LEN.
- start in LEN, DATA or WRITE is ignored.
- Word count and byte index counters are sized for MAX_WORDS and 0–3 respectively. Address arithmetic is modulo 2^A_WIDTH. With N≤MAX_WORDS the address never leaves the BASE window.
- The memory accepts a write every cycle; there is no write back-pressure.

## Timing
- Reset (async assert, sync release) puts every output at its reset value:
  - state=IDLE, byte_ready=0, mem_we=0, mem_addr=BASE, mem_wdata=0
  - busy=0, done=0, err=0, cpu_rst_n=0
- Reset asserted mid-load aborts the load immediately. Words already written stay in memory, and the loader restarts from IDLE.
- byte_ready is a registered function of state only; it never depends on byte_valid in the same cycle.
- From start high to byte_ready high is 1 cycle.
- From the 4th byte of a word accepted to mem_we high is 1 cycle.
- Steady-state throughput is 1 word per 5 cycles: 4 accepts plus 1 write.
- From the last mem_we to done=1 and cpu_rst_n=1 is 1 cycle.
- mem_addr and mem_wdata are stable for the whole mem_we cycle. mem_wdata holds its last value outside WRITE.
- Gaps in byte_valid stall the loader with no penalty and no timeout.

## Test plan
- Reset then start; stream header 00 00 00 02, then DE AD BE EF 12 34 56 78 with byte_valid held high.
  - Required: mem_we at 0xBFC00000 with 0xDEADBEEF, then at 0xBFC00004 with 0x12345678, each 5 cycles apart.
  - Then done=1 and cpu_rst_n=1.
- Same stream with byte_valid toggled every other cycle → identical writes. byte_ready stays high in DATA and low only in WRITE cycles.
- Header 00 00 00 00 → no mem_we. done=1 one cycle after the 4th header byte.
- Header 00 00 04 01 (1025 > MAX_WORDS) → err=1, byte_ready=0, no writes, cpu_rst_n stays 0. A following start re-enters LEN and clears err.
- rst_n pulsed low after 6 data bytes of a 2-word load → all outputs return to reset values asynchronously. A fresh load then writes again from 0xBFC00000.
- start pulsed during DATA → ignored: no counter reset and the address sequence is unchanged. start after DONE with header 00 00 00 01 and word 00 00 00 13 → cpu_rst_n low, then a write of 0x00000013 at 0xBFC00000.
